// File: rtl/xbar_sram_bank_if.sv
// Crossbar peripheral-port bundle: the port arbiter drives the request side (master),
// the SRAM bank answers with ready/rvalid/rdata (slave).
interface xbar_sram_bank_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic                  req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wen;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic                  ready;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, addr, wen, wdata, be, input ready, rvalid, rdata);
  modport slave  (input req, addr, wen, wdata, be, output ready, rvalid, rdata);
endinterface

// File: rtl/xbar_sram_bank.sv
// Word-addressed single-port SRAM target for one crossbar peripheral port.
// Define XBAR_SRAM_BANK_WAIT_EN to insert WAIT_CYCLES programmable wait states before ready.
module xbar_sram_bank #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk_i,
  input logic             rst_ni,
  xbar_sram_bank_if.slave p
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH > (1 << ADDR_WIDTH) || WAIT_CYCLES < 1) begin : g_bad_params
    $error("xbar_sram_bank: illegal DEPTH/WAIT_CYCLES for this ADDR_WIDTH");
  end

  logic [31:0]      mem [DEPTH];
  logic             ready;
  logic             accept;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             rvalid_q;
  logic [31:0]      rdata_q;

  assign accept   = p.req & ready;
  assign in_range = 32'(p.addr) < DEPTH;
  assign idx      = p.addr[IDX_W-1:0];

  // Reset gates the write so an access caught by reset never lands in memory.
  always_ff @(posedge clk_i) begin
    if (rst_ni && accept && p.wen && in_range) begin
      for (int n = 0; n < 4; n++) begin
        if (p.be[n]) mem[idx][8*n +: 8] <= p.wdata[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= accept & ~p.wen;
      if (accept && !p.wen) rdata_q <= in_range ? mem[idx] : 32'h0;
    end
  end

  assign p.rvalid = rvalid_q;
  assign p.rdata  = rdata_q;
  assign p.ready  = ready;

`ifdef XBAR_SRAM_BANK_WAIT_EN
  typedef enum logic [1:0] {IDLE, COUNT, GRANT} state_t;

  localparam int             CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter keeps running across address changes; only a dropped req restarts it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (p.req) begin
          if (WAIT_CYCLES == 1) begin
            state_d = GRANT;
            cnt_d   = '0;
          end else begin
            state_d = COUNT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      COUNT: begin
        if (!p.req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = GRANT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ready = (state_q == GRANT);
`else
  logic ready_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ready_q <= 1'b0;
    else         ready_q <= 1'b1;
  end

  assign ready = ready_q;
`endif
endmodule

// File: tb/tb_xbar_sram_bank.sv
// Self-checking bench for xbar_sram_bank: directed cases plus random traffic
// against a byte-level memory model; adapts to the XBAR_SRAM_BANK_WAIT_EN build.
`timescale 1ns/1ps
module tb_xbar_sram_bank;
  localparam int ADDR_WIDTH  = 10;
  localparam int DEPTH       = 1000;
  localparam int WAIT_CYCLES = 2;
`ifdef XBAR_SRAM_BANK_WAIT_EN
  localparam int EXP_LAT = WAIT_CYCLES;
`else
  localparam int EXP_LAT = 0;
`endif

  logic        clk_i  = 1'b0;
  logic        rst_ni = 1'b0;
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] ref_mem [int];
  logic [31:0] last_rdata = 32'h0;

  xbar_sram_bank_if #(.ADDR_WIDTH(ADDR_WIDTH)) bus ();

  xbar_sram_bank #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .p     (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic req, input logic [ADDR_WIDTH-1:0] addr,
                               input logic wen, input logic [31:0] wdata, input logic [3:0] be);
    bus.req   = req;
    bus.addr  = addr;
    bus.wen   = wen;
    bus.wdata = wdata;
    bus.be    = be;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [ADDR_WIDTH-1:0] a);
    if (int'(a) >= DEPTH) return 32'h0;
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'hxxxxxxxx;
  endfunction

  function automatic void refWrite(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    if (int'(a) >= DEPTH) return;
    w = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'hxxxxxxxx;
    for (int n = 0; n < 4; n++) if (be[n]) w[8*n +: 8] = d[8*n +: 8];
    ref_mem[int'(a)] = w;
  endfunction

  task automatic applyIdle();
    applyStimulus(1'b0, ADDR_WIDTH'($urandom), 1'($urandom), $urandom, 4'($urandom));
  endtask

  // One complete access, called at a falling edge; returns at the falling edge after acceptance.
  task automatic doAccess(input logic wen, input logic [ADDR_WIDTH-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
    int          waited;
    logic [31:0] exp;
    applyStimulus(1'b1, addr, wen, wdata, be);
    waited = 0;
    #1;
    while (bus.ready !== 1'b1 && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("ready_latency", 32'(waited), 32'(EXP_LAT));
    @(posedge clk_i);
    #1;
    applyIdle();
    exp = wen ? last_rdata : refRead(addr);
    if (wen) refWrite(addr, wdata, be);
    @(negedge clk_i);
    checkOutput("rvalid", 32'(bus.rvalid), 32'(!wen));
    checkOutput(wen ? "rdata_hold" : "rdata", bus.rdata, exp);
    checkOutput("ready_after", 32'(bus.ready), 32'(EXP_LAT == 0));
    if (!wen) last_rdata = exp;
  endtask

  initial begin
    logic [ADDR_WIDTH-1:0] a;
    int                    waited;
    applyIdle();
    repeat (3) @(negedge clk_i);
    checkOutput("reset_ready", 32'(bus.ready), 32'h0);
    checkOutput("reset_rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("reset_rdata", bus.rdata, 32'h0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("ready_post_reset", 32'(bus.ready), 32'(EXP_LAT == 0));

    for (int i = 0; i < 16; i++) doAccess(1'b1, ADDR_WIDTH'(i), $urandom, 4'hF);

`ifdef XBAR_SRAM_BANK_WAIT_EN
    doAccess(1'b1, 10'd5, 32'h11223344, 4'hF);
    doAccess(1'b0, 10'd5, 32'h0, 4'h0);
    checkOutput("wr_rd_const", bus.rdata, 32'h11223344);
`else
    // Back-to-back write then read with no idle cycle in between.
    applyStimulus(1'b1, 10'd5, 1'b1, 32'h11223344, 4'hF);
    #1;
    checkOutput("b2b_ready_wr", 32'(bus.ready), 32'h1);
    @(posedge clk_i);
    #1;
    refWrite(10'd5, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 10'd5, 1'b0, $urandom, 4'($urandom));
    checkOutput("b2b_ready_rd", 32'(bus.ready), 32'h1);
    @(posedge clk_i);
    #1;
    applyIdle();
    @(negedge clk_i);
    checkOutput("b2b_rvalid", 32'(bus.rvalid), 32'h1);
    checkOutput("b2b_rdata", bus.rdata, 32'h11223344);
    last_rdata = 32'h11223344;
    @(negedge clk_i);
    checkOutput("rvalid_pulse", 32'(bus.rvalid), 32'h0);
`endif

    doAccess(1'b1, 10'd7, 32'hAABBCCDD, 4'hF);
    doAccess(1'b1, 10'd7, 32'h00000055, 4'b0001);
    doAccess(1'b0, 10'd7, 32'h0, 4'h0);
    checkOutput("be_merge_const", bus.rdata, 32'hAABBCC55);

    doAccess(1'b1, 10'd1010, 32'hFFFFFFFF, 4'hF);
    doAccess(1'b0, 10'd1010, 32'h0, 4'h0);
    checkOutput("oor_rdata_const", bus.rdata, 32'h0);

`ifdef XBAR_SRAM_BANK_WAIT_EN
    begin
      logic [7:0] rdy_bits, rv_bits, exp_rdy, exp_rv;
      applyStimulus(1'b1, 10'd5, 1'b0, 32'h0, 4'h0);
      for (int k = 0; k < 8; k++) begin
        if (k == 0) #1;
        else @(negedge clk_i);
        rdy_bits[k] = bus.ready;
        rv_bits[k]  = bus.rvalid;
        exp_rdy[k]  = (k == WAIT_CYCLES) || (k == 2 * WAIT_CYCLES + 1);
        exp_rv[k]   = (k == WAIT_CYCLES + 1) || (k == 2 * WAIT_CYCLES + 2);
      end
      applyIdle();
      checkOutput("held_ready", 32'(rdy_bits), 32'(exp_rdy));
      checkOutput("held_rvalid", 32'(rv_bits), 32'(exp_rv));
      checkOutput("held_rdata", bus.rdata, refRead(10'd5));
      last_rdata = refRead(10'd5);
      @(negedge clk_i);
      @(negedge clk_i);
    end
    // Requester withdraws on the grant cycle: no access may happen.
    begin
      logic rv_seen;
      applyStimulus(1'b1, 10'd9, 1'b1, 32'hDEADBEEF, 4'hF);
      repeat (WAIT_CYCLES) @(negedge clk_i);
      applyIdle();
      rv_seen = 1'b0;
      repeat (3) begin
        @(negedge clk_i);
        rv_seen = rv_seen | bus.rvalid;
      end
      checkOutput("withdraw_rvalid", 32'(rv_seen), 32'h0);
      doAccess(1'b0, 10'd9, 32'h0, 4'h0);
    end
`endif

    // Reset lands while a write is being granted.
    applyStimulus(1'b1, 10'd3, 1'b1, 32'h5A5A5A5A, 4'hF);
    waited = 0;
    #1;
    while (bus.ready !== 1'b1 && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput("rst_pre_ready", 32'(waited), 32'(EXP_LAT));
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    checkOutput("rst_mid_ready", 32'(bus.ready), 32'h0);
    checkOutput("rst_mid_rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("rst_mid_rdata", bus.rdata, 32'h0);
    applyIdle();
    last_rdata = 32'h0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rst_after_rvalid", 32'(bus.rvalid), 32'h0);
    @(negedge clk_i);
    doAccess(1'b0, 10'd3, 32'h0, 4'h0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) a = ADDR_WIDTH'(1000 + $urandom_range(0, 23));
      else                           a = ADDR_WIDTH'($urandom_range(0, 15));
      doAccess(1'($urandom), a, $urandom, 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
